// File: rtl/tag_caster_if.sv
// Bus-side and PE-side handshake bundle for tag_caster.
// master drives beats and PE_READY; slave is the caster itself.
interface tag_caster_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4
);
  localparam int unsigned IW = $clog2(NUM_COL);

  logic                  CASTER_EN;
  logic [DATA_WIDTH-1:0] data_B2C;
  logic [IW-1:0]         TAG;
  logic                  CASTER_READY;
  logic                  CASTER_VALID;
  logic [DATA_WIDTH-1:0] data_C2P;
  logic                  PE_READY;
  logic                  PE_EN;

  modport master (
    output CASTER_EN, data_B2C, TAG, PE_READY,
    input  CASTER_READY, CASTER_VALID, data_C2P, PE_EN
  );

  modport slave (
    input  CASTER_EN, data_B2C, TAG, PE_READY,
    output CASTER_READY, CASTER_VALID, data_C2P, PE_EN
  );
endinterface

// File: rtl/tag_caster.sv
// Tag-filtering caster: keeps bus beats whose TAG matches ID in a small FIFO for the PE.
// Optional drop counter enabled by defining TAG_CASTER_DROP_CNT_EN.
module tag_caster #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tag_caster_if.slave                intf,
  input  logic [$clog2(NUM_COL)-1:0] ID,
  input  logic                       flush
`ifdef TAG_CASTER_DROP_CNT_EN
  , output logic [15:0]              drop_cnt
`endif
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_ready;
  logic w_valid;
  logic w_accept;
  logic w_match;
  logic w_push;
  logic w_pop;

  assign w_ready  = (r_count != CW'(FIFO_DEPTH)) && !flush;
  assign w_valid  = (r_count != '0);
  assign w_accept = intf.CASTER_EN && w_ready;
  assign w_match  = (intf.TAG == ID);
  assign w_push   = w_accept && w_match;
  assign w_pop    = w_valid && intf.PE_READY && !flush;

  assign intf.CASTER_READY = w_ready;
  assign intf.CASTER_VALID = w_valid;
  assign intf.PE_EN        = w_pop;
  assign intf.data_C2P     = w_valid ? r_mem[r_rd_ptr] : '0;

  // Storage is left unreset; the output mux hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= intf.data_B2C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef TAG_CASTER_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = w_accept && !w_match;

  // Survives flush; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif
endmodule

// File: doc/tag_caster.md
TAG_CASTER -- requirements
Module: tag_caster

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the data words.
REQ-002 Parameter NUM_COL, default 4, SHALL set the number of columns; ID/TAG width SHALL be IW = $clog2(NUM_COL).
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the buffer depth and SHALL be a power of two, >= 2.
REQ-004 clk  input  1  SHALL be the single clock, with all state updated on the rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 CASTER_EN  input  1  SHALL mean the bus offers a beat this cycle.
REQ-007 data_B2C  input  DATA_WIDTH  SHALL carry the bus data word.
REQ-008 TAG  input  IW  SHALL carry the destination column tag of the offered beat.
REQ-009 ID  input  IW  SHALL carry this caster's column index, static during operation.
REQ-010 flush  input  1  SHALL request a synchronous clear of the buffer.
REQ-011 CASTER_READY  output  1  SHALL mean the caster accepts a beat this cycle.
REQ-012 CASTER_VALID  output  1  SHALL mean data_C2P holds a valid word for the PE.
REQ-013 data_C2P  output  DATA_WIDTH  SHALL carry the data word to the PE.
REQ-014 PE_READY  input  1  SHALL mean the PE accepts data_C2P this cycle.
REQ-015 PE_EN  output  1  SHALL pulse for exactly one cycle per word transferred to the PE.

Function
REQ-016 A bus beat SHALL be consumed when CASTER_EN && CASTER_READY.
REQ-017 When a beat is consumed with TAG == ID, data_B2C SHALL be pushed into the FIFO.
REQ-018 When a beat is consumed with TAG != ID, it SHALL be dropped; the FIFO is unchanged and the bus handshake still completes.
REQ-019 CASTER_READY SHALL equal (count != FIFO_DEPTH) && !flush, combinationally.
- Accordingly, a full FIFO SHALL stall all beats, matching and non-matching alike.
REQ-020 CASTER_VALID SHALL equal (count != 0); data_C2P SHALL be the FIFO head when valid and all-zero when empty.
REQ-021 A pop SHALL occur when CASTER_VALID && PE_READY && !flush; PE_EN SHALL equal that pop condition.
REQ-022 Latency: a matching beat consumed in cycle N SHALL appear on data_C2P with CASTER_VALID in cycle N+1; there is no same-cycle bypass.
REQ-023 Simultaneous push and pop SHALL both occur and leave count unchanged; order is strictly FIFO.
REQ-024 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and SHALL wrap modulo FIFO_DEPTH.
- count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-025 flush SHALL zero count and both pointers at the next edge; no push, pop or PE_EN SHALL occur in a flush cycle.
REQ-026 A pop while empty or a push while full SHALL never occur; pointers SHALL never move in those cases.

Reset
REQ-027 While rst_n is low, count, pointers and (if present) drop_cnt SHALL be 0, with immediate effect and no clock required.
REQ-028 The outputs SHALL then read: CASTER_VALID=0, data_C2P=0, PE_EN=0, CASTER_READY=1.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; no PE_EN SHALL follow reset release until a new matching beat is consumed.
REQ-030 FIFO storage need not be reset, since data_C2P is gated to 0 when empty.

Configuration
REQ-031 With macro TAG_CASTER_DROP_CNT_EN defined, the block SHALL add output drop_cnt [15:0].
- drop_cnt SHALL increment once per consumed non-matching beat and saturate at 16'hFFFF.
- flush SHALL NOT clear drop_cnt; only reset clears it.
REQ-032 Without TAG_CASTER_DROP_CNT_EN, the drop_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 The bench SHALL check reset and a single match: ID=2; after reset, CASTER_READY=1 and CASTER_VALID=0.
- Stimulus: one beat TAG=2, data 16'hA5A5, PE_READY=1.
- Response: next cycle CASTER_VALID=1, data_C2P=16'hA5A5, PE_EN=1; the following cycle CASTER_VALID=0.
REQ-034 The bench SHALL check filtering: ID=1; beats TAG=0,1,3,1 with data 1,2,3,4.
- Response: the PE receives exactly 2 then 4.
- With the macro defined, drop_cnt SHALL read 2.
REQ-035 The bench SHALL check full/backpressure: PE_READY=0; five matching beats 10..14 offered back-to-back.
- Response: four are accepted; CASTER_READY=0 on the fifth.
- Then PE_READY=1: the PE receives 10,11,12,13, then 14 after it is accepted.
REQ-036 The bench SHALL check simultaneous push/pop with wrap: count=1 and PE_READY=1, with 12 consecutive matching beats.
- Response: count stays 1 throughout, pointers wrap at least twice, and the output order equals the input order.
REQ-037 The bench SHALL check flush: with 3 words buffered, pulse flush for one cycle while CASTER_EN=1.
- Response: that beat is not accepted; the next cycle CASTER_VALID=0 and count=0.
REQ-038 The bench SHALL check reset mid-operation: with 2 words buffered and PE_READY=1, drop rst_n asynchronously mid-cycle.
- Response: CASTER_VALID=0 and PE_EN=0 immediately, and no stale word appears after release.
